// File: rtl/motor_bus_regfile.sv
// Avalon-MM per-motor register file with comms-side status/config ports and dirty tracking.
// Define SHADOW_COMMIT_EN to stage setpoints in shadows and apply them on a write to 0x20.
module motor_bus_regfile #(
  parameter int unsigned NUMBER_OF_MOTORS     = 10,
  parameter int unsigned DATA_WIDTH           = 32,
  parameter int unsigned ENC_WIDTH            = 16,
  parameter int unsigned ID_BASE              = 128,
  parameter int unsigned DEFAULT_BAUDRATE     = 19200,
  parameter int unsigned DEFAULT_CONTROL_MODE = 3
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [15:0]                            address,
  input  logic                                   write,
  input  logic [31:0]                            writedata,
  input  logic                                   read,
  output logic [31:0]                            readdata,
  output logic                                   waitrequest,
  input  logic                                   stat_valid,
  input  logic [7:0]                             stat_motor,
  input  logic [1:0]                             stat_sel,
  input  logic [DATA_WIDTH-1:0]                  stat_data,
  input  logic [7:0]                             cfg_motor,
  input  logic [2:0]                             cfg_sel,
  output logic [DATA_WIDTH-1:0]                  cfg_data,
  output logic [NUMBER_OF_MOTORS-1:0]            dirty,
  input  logic                                   dirty_clr_valid,
  input  logic [7:0]                             dirty_clr_motor,
  output logic [NUMBER_OF_MOTORS*DATA_WIDTH-1:0] sp_flat,
  output logic                                   update_pulse,
  output logic [31:0]                            baudrate,
  output logic [31:0]                            update_frequency_Hz
);

  localparam logic [7:0] AddrEnc0     = 8'h04;
  localparam logic [7:0] AddrEnc1     = 8'h05;
  localparam logic [7:0] AddrSetpoint = 8'h0C;
  localparam logic [7:0] AddrErrCode  = 8'h0D;
  localparam logic [7:0] AddrShadow   = 8'h0E;
  localparam logic [7:0] AddrFreq     = 8'h11;
  localparam logic [7:0] AddrCurrent  = 8'h19;
  localparam logic [7:0] AddrBaud     = 8'h1D;
  localparam logic [7:0] AddrCommit   = 8'h20;
  localparam logic [7:0] AddrDirty    = 8'h21;
  localparam logic [7:0] AddrBusErr   = 8'h22;

  typedef struct packed {
    logic [7:0]            id;
    logic [DATA_WIDTH-1:0] kp, ki, kd, pwm_limit, integral_limit, deadband;
    logic [7:0]            control_mode;
    logic [ENC_WIDTH-1:0]  enc0, enc1;
    logic [DATA_WIDTH-1:0] current, error_code, sp_shadow, sp_active;
  } motor_t;

  motor_t                      mot_q [NUMBER_OF_MOTORS];
  motor_t                      mot_d [NUMBER_OF_MOTORS];
  logic [NUMBER_OF_MOTORS-1:0] dirty_q, dirty_d, dirty_set;
  logic [2:0]                  bus_error_q, bus_error_d, err_set;
  logic                        err_clr;
  logic [31:0]                 baudrate_q, baudrate_d, freq_q, freq_d;
  logic [31:0]                 readdata_q, readdata_d;
  logic                        armed_q, armed_d;
  logic                        pulse_q, pulse_d;
  logic [DATA_WIDTH-1:0]       cfg_data_q, cfg_data_d;

  logic [7:0] addr, motor;
  logic       is_cfg, per_motor, motor_ok;
  logic [2:0] cfg_idx;

  function automatic motor_t motor_reset(int unsigned idx);
    motor_t r;
    r              = '0;
    r.id           = 8'(ID_BASE + idx);
    r.control_mode = 8'(DEFAULT_CONTROL_MODE);
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] cfg_field(motor_t m, logic [2:0] sel);
    logic [DATA_WIDTH-1:0] v;
    unique case (sel)
      3'd0:    v = DATA_WIDTH'(m.id);
      3'd1:    v = m.kp;
      3'd2:    v = m.ki;
      3'd3:    v = m.kd;
      3'd4:    v = m.pwm_limit;
      3'd5:    v = m.integral_limit;
      3'd6:    v = m.deadband;
      default: v = DATA_WIDTH'(m.control_mode);
    endcase
    return v;
  endfunction

  function automatic motor_t cfg_write(motor_t m, logic [2:0] sel, logic [31:0] wd);
    motor_t r;
    r = m;
    unique case (sel)
      3'd0:    r.id             = wd[7:0];
      3'd1:    r.kp             = DATA_WIDTH'(wd);
      3'd2:    r.ki             = DATA_WIDTH'(wd);
      3'd3:    r.kd             = DATA_WIDTH'(wd);
      3'd4:    r.pwm_limit      = DATA_WIDTH'(wd);
      3'd5:    r.integral_limit = DATA_WIDTH'(wd);
      3'd6:    r.deadband       = DATA_WIDTH'(wd);
      default: r.control_mode   = wd[7:0];
    endcase
    return r;
  endfunction

  function automatic logic [31:0] host_field(motor_t m, logic [7:0] a, logic cfg,
                                             logic [2:0] sel);
    logic [31:0] v;
    v = 32'hDEADBEEF;
    if (cfg) begin
      v = 32'(cfg_field(m, sel));
    end else begin
      case (a)
        AddrEnc0:     v = 32'($signed(m.enc0));
        AddrEnc1:     v = 32'($signed(m.enc1));
        AddrCurrent:  v = 32'(m.current);
        AddrErrCode:  v = 32'(m.error_code);
        AddrSetpoint: v = 32'(m.sp_active);
`ifdef SHADOW_COMMIT_EN
        AddrShadow:   v = 32'(m.sp_shadow);
`else
        AddrShadow:   v = 32'(m.sp_active);
`endif
        default:      v = 32'hDEADBEEF;
      endcase
    end
    return v;
  endfunction

  // Config regs occupy 0x00-0x03 and 0x08-0x0B, so {a[3], a[1:0]} is the cfg_sel index.
  assign addr      = address[15:8];
  assign motor     = address[7:0];
  assign is_cfg    = (addr[7:4] == 4'h0) && !addr[2];
  assign cfg_idx   = {addr[3], addr[1:0]};
  assign per_motor = is_cfg || (addr == AddrEnc0) || (addr == AddrEnc1) ||
                     (addr == AddrCurrent) || (addr == AddrErrCode) ||
                     (addr == AddrSetpoint) || (addr == AddrShadow);
  assign motor_ok  = 32'(motor) < NUMBER_OF_MOTORS;

  always_comb begin
    mot_d       = mot_q;
    dirty_d     = dirty_q;
    dirty_set   = '0;
    baudrate_d  = baudrate_q;
    freq_d      = freq_q;
    readdata_d  = readdata_q;
    armed_d     = read & ~armed_q;
    pulse_d     = 1'b0;
    err_set     = '0;
    err_clr     = 1'b0;
    cfg_data_d  = '0;

    // Host read is captured in its first cycle; the second cycle presents it.
    if (read && !armed_q) begin
      readdata_d = 32'hDEADBEEF;
      if (per_motor) begin
        if (motor_ok) begin
          for (int i = 0; i < NUMBER_OF_MOTORS; i++) begin
            if (motor == i[7:0]) readdata_d = host_field(mot_q[i], addr, is_cfg, cfg_idx);
          end
        end else begin
          err_set[0] = 1'b1;
        end
      end else begin
        case (addr)
          AddrFreq:   readdata_d = freq_q;
          AddrBaud:   readdata_d = baudrate_q;
          AddrCommit: readdata_d = '0;
          AddrDirty:  readdata_d = 32'(dirty_q);
          AddrBusErr: begin
            readdata_d = {29'd0, bus_error_q};
            err_clr    = 1'b1;
          end
          default:    err_set[2] = 1'b1;
        endcase
      end
    end

    if (write) begin
      if (per_motor) begin
        if (!motor_ok) begin
          err_set[1] = 1'b1;
        end else begin
          for (int i = 0; i < NUMBER_OF_MOTORS; i++) begin
            if (motor == i[7:0]) begin
              if (is_cfg) begin
                mot_d[i]     = cfg_write(mot_q[i], cfg_idx, writedata);
                dirty_set[i] = 1'b1;
              end else if (addr == AddrSetpoint) begin
`ifdef SHADOW_COMMIT_EN
                mot_d[i].sp_shadow = DATA_WIDTH'(writedata);
`else
                mot_d[i].sp_active = DATA_WIDTH'(writedata);
                pulse_d            = 1'b1;
`endif
              end
            end
          end
        end
      end else begin
        case (addr)
          AddrFreq: freq_d     = writedata;
          AddrBaud: baudrate_d = writedata;
`ifdef SHADOW_COMMIT_EN
          AddrCommit: begin
            for (int i = 0; i < NUMBER_OF_MOTORS; i++) mot_d[i].sp_active = mot_q[i].sp_shadow;
            pulse_d = 1'b1;
          end
`endif
          default: ;
        endcase
      end
    end

    for (int i = 0; i < NUMBER_OF_MOTORS; i++) begin
      if (stat_valid && stat_motor == i[7:0]) begin
        unique case (stat_sel)
          2'd0:    mot_d[i].enc0       = stat_data[ENC_WIDTH-1:0];
          2'd1:    mot_d[i].enc1       = stat_data[ENC_WIDTH-1:0];
          2'd2:    mot_d[i].current    = stat_data;
          default: mot_d[i].error_code = stat_data;
        endcase
      end
      if (dirty_clr_valid && dirty_clr_motor == i[7:0]) dirty_d[i] = 1'b0;
      if (cfg_motor == i[7:0]) cfg_data_d = cfg_field(mot_q[i], cfg_sel);
    end
    dirty_d     = dirty_d | dirty_set;
    bus_error_d = (err_clr ? 3'b000 : bus_error_q) | err_set;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUMBER_OF_MOTORS; i++) mot_q[i] <= motor_reset(i);
      dirty_q     <= '0;
      bus_error_q <= '0;
      baudrate_q  <= DEFAULT_BAUDRATE;
      freq_q      <= 32'd1;
      readdata_q  <= '0;
      armed_q     <= 1'b0;
      pulse_q     <= 1'b0;
      cfg_data_q  <= '0;
    end else begin
      mot_q       <= mot_d;
      dirty_q     <= dirty_d;
      bus_error_q <= bus_error_d;
      baudrate_q  <= baudrate_d;
      freq_q      <= freq_d;
      readdata_q  <= readdata_d;
      armed_q     <= armed_d;
      pulse_q     <= pulse_d;
      cfg_data_q  <= cfg_data_d;
    end
  end

  always_comb begin
    sp_flat = '0;
    for (int i = 0; i < NUMBER_OF_MOTORS; i++) begin
      sp_flat[i*DATA_WIDTH +: DATA_WIDTH] = mot_q[i].sp_active;
    end
  end

  // Gated by reset so an in-flight read drops waitrequest the moment reset asserts.
  assign waitrequest         = read & ~armed_q & reset;
  assign readdata            = readdata_q;
  assign cfg_data            = cfg_data_q;
  assign dirty               = dirty_q;
  assign update_pulse        = pulse_q;
  assign baudrate            = baudrate_q;
  assign update_frequency_Hz = freq_q;

endmodule

// File: tb/tb_motor_bus_regfile.sv
// Self-checking bench for motor_bus_regfile: directed register-map checks followed by
// randomized host/status/config traffic against a register-map level reference model.
module tb_motor_bus_regfile;

  localparam int NM = 10;
  localparam logic [7:0] ADDRS [20] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h08,
                                        8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h11,
                                        8'h19, 8'h1D, 8'h20, 8'h21, 8'h22, 8'h0C};

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [15:0]       address = '0;
  logic              write = 1'b0;
  logic [31:0]       writedata = '0;
  logic              read = 1'b0;
  logic [31:0]       readdata;
  logic              waitrequest;
  logic              stat_valid = 1'b0;
  logic [7:0]        stat_motor = '0;
  logic [1:0]        stat_sel = '0;
  logic [31:0]       stat_data = '0;
  logic [7:0]        cfg_motor = '0;
  logic [2:0]        cfg_sel = '0;
  logic [31:0]       cfg_data;
  logic [NM-1:0]     dirty;
  logic              dirty_clr_valid = 1'b0;
  logic [7:0]        dirty_clr_motor = '0;
  logic [NM*32-1:0]  sp_flat;
  logic              update_pulse;
  logic [31:0]       baudrate;
  logic [31:0]       update_frequency_Hz;

  always #5 clk = ~clk;

  motor_bus_regfile dut (
    .clk                 (clk),
    .reset               (reset),
    .address             (address),
    .write               (write),
    .writedata           (writedata),
    .read                (read),
    .readdata            (readdata),
    .waitrequest         (waitrequest),
    .stat_valid          (stat_valid),
    .stat_motor          (stat_motor),
    .stat_sel            (stat_sel),
    .stat_data           (stat_data),
    .cfg_motor           (cfg_motor),
    .cfg_sel             (cfg_sel),
    .cfg_data            (cfg_data),
    .dirty               (dirty),
    .dirty_clr_valid     (dirty_clr_valid),
    .dirty_clr_motor     (dirty_clr_motor),
    .sp_flat             (sp_flat),
    .update_pulse        (update_pulse),
    .baudrate            (baudrate),
    .update_frequency_Hz (update_frequency_Hz)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: cfg regs by cfg_sel index, status regs by stat_sel index.
  logic [31:0]   m_cfg  [NM][8];
  logic [31:0]   m_stat [NM][4];
  logic [31:0]   m_sh   [NM];
  logic [31:0]   m_act  [NM];
  logic [NM-1:0] m_dirty;
  logic [2:0]    m_berr;
  logic [31:0]   m_baud, m_freq, m_rdata, m_cfgd;
  logic          m_pulse, m_armed;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  function automatic int cfg_index(input logic [7:0] a);
    case (a)
      8'h00: return 0;
      8'h01: return 1;
      8'h02: return 2;
      8'h03: return 3;
      8'h08: return 4;
      8'h09: return 5;
      8'h0A: return 6;
      8'h0B: return 7;
      default: return -1;
    endcase
  endfunction

  function automatic bit is_pm(input logic [7:0] a);
    return cfg_index(a) >= 0 || a == 8'h04 || a == 8'h05 || a == 8'h19 || a == 8'h0D ||
           a == 8'h0C || a == 8'h0E;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NM; i++) begin
      for (int s = 0; s < 8; s++) m_cfg[i][s] = 32'd0;
      for (int s = 0; s < 4; s++) m_stat[i][s] = 32'd0;
      m_cfg[i][0] = 32'd128 + 32'(i);
      m_cfg[i][7] = 32'd3;
      m_sh[i]     = 32'd0;
      m_act[i]    = 32'd0;
    end
    m_dirty = '0;
    m_berr  = '0;
    m_baud  = 32'd19200;
    m_freq  = 32'd1;
    m_rdata = '0;
    m_cfgd  = '0;
    m_pulse = 1'b0;
    m_armed = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs presented in the ending cycle.
  task automatic model_step();
    logic [7:0]    a, mo;
    logic [2:0]    err;
    logic          clr, nx_pulse, nx_armed;
    logic [31:0]   v, nx_cfg;
    logic [NM-1:0] setm;
    int            s;
    a        = address[15:8];
    mo       = address[7:0];
    err      = '0;
    clr      = 1'b0;
    setm     = '0;
    nx_pulse = 1'b0;
    nx_cfg   = (int'(cfg_motor) < NM) ? m_cfg[int'(cfg_motor)][int'(cfg_sel)] : 32'd0;
    nx_armed = 1'b0;
    if (read && !m_armed) begin
      v = 32'hDEADBEEF;
      if (is_pm(a)) begin
        if (int'(mo) >= NM) err[0] = 1'b1;
        else begin
          s = cfg_index(a);
          if (s >= 0) v = m_cfg[int'(mo)][s];
          else case (a)
            8'h04: v = m_stat[int'(mo)][0];
            8'h05: v = m_stat[int'(mo)][1];
            8'h19: v = m_stat[int'(mo)][2];
            8'h0D: v = m_stat[int'(mo)][3];
            8'h0C: v = m_act[int'(mo)];
`ifdef SHADOW_COMMIT_EN
            default: v = m_sh[int'(mo)];
`else
            default: v = m_act[int'(mo)];
`endif
          endcase
        end
      end else begin
        case (a)
          8'h11: v = m_freq;
          8'h1D: v = m_baud;
          8'h20: v = 32'd0;
          8'h21: v = 32'(m_dirty);
          8'h22: begin v = {29'd0, m_berr}; clr = 1'b1; end
          default: err[2] = 1'b1;
        endcase
      end
      m_rdata  = v;
      nx_armed = 1'b1;
    end
    if (write) begin
      if (is_pm(a)) begin
        if (int'(mo) >= NM) err[1] = 1'b1;
        else begin
          s = cfg_index(a);
          if (s >= 0) begin
            m_cfg[int'(mo)][s] = (s == 0 || s == 7) ? {24'd0, writedata[7:0]} : writedata;
            setm[int'(mo)] = 1'b1;
          end else if (a == 8'h0C) begin
`ifdef SHADOW_COMMIT_EN
            m_sh[int'(mo)] = writedata;
`else
            m_act[int'(mo)] = writedata;
            nx_pulse = 1'b1;
`endif
          end
        end
      end else if (a == 8'h11) m_freq = writedata;
      else if (a == 8'h1D) m_baud = writedata;
      else if (a == 8'h20) begin
`ifdef SHADOW_COMMIT_EN
        for (int i = 0; i < NM; i++) m_act[i] = m_sh[i];
        nx_pulse = 1'b1;
`endif
      end
    end
    if (stat_valid && int'(stat_motor) < NM) begin
      if (stat_sel < 2) m_stat[int'(stat_motor)][int'(stat_sel)] =
          {{16{stat_data[15]}}, stat_data[15:0]};
      else m_stat[int'(stat_motor)][int'(stat_sel)] = stat_data;
    end
    if (dirty_clr_valid && int'(dirty_clr_motor) < NM) m_dirty[int'(dirty_clr_motor)] = 1'b0;
    m_dirty = m_dirty | setm;
    m_berr  = (clr ? 3'b000 : m_berr) | err;
    m_cfgd  = nx_cfg;
    m_pulse = nx_pulse;
    m_armed = nx_armed;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      check("readdata", readdata, m_rdata);
      check("waitrequest", {31'd0, waitrequest}, {31'd0, read & ~m_armed});
      check("cfg_data", cfg_data, m_cfgd);
      check("dirty", 32'(dirty), 32'(m_dirty));
      check("update_pulse", {31'd0, update_pulse}, {31'd0, m_pulse});
      check("baudrate", baudrate, m_baud);
      check("update_frequency_Hz", update_frequency_Hz, m_freq);
      for (int i = 0; i < NM; i++) check("sp_flat", sp_flat[i*32 +: 32], m_act[i]);
    end
  end

  task automatic tick();
    @(posedge clk);
    if (reset) model_step();
    #1;
  endtask

  task automatic host_read(input logic [7:0] a, input logic [7:0] m, output logic [31:0] d);
    address = {a, m};
    read    = 1'b1;
    #1;
    check("wait_first_cycle", {31'd0, waitrequest}, 32'd1);
    tick();
    check("wait_second_cycle", {31'd0, waitrequest}, 32'd0);
    d = readdata;
    tick();
    read = 1'b0;
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] m, input logic [31:0] wd);
    address   = {a, m};
    writedata = wd;
    write     = 1'b1;
    tick();
    write = 1'b0;
  endtask

  task automatic rand_side();
    stat_valid      = ($urandom_range(0, 2) == 0);
    stat_motor      = 8'($urandom_range(0, 12));
    stat_sel        = 2'($urandom);
    stat_data       = $urandom;
    cfg_motor       = 8'($urandom_range(0, 11));
    cfg_sel         = 3'($urandom);
    dirty_clr_valid = ($urandom_range(0, 3) == 0);
    dirty_clr_motor = 8'($urandom_range(0, 11));
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  ra, rm;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    check("rst_readdata", readdata, 32'd0);
    check("rst_waitrequest", {31'd0, waitrequest}, 32'd0);
    check("rst_dirty", 32'(dirty), 32'd0);
    check("rst_sp2", sp_flat[64 +: 32], 32'd0);
    check("rst_baudrate", baudrate, 32'd19200);
    check("rst_freq", update_frequency_Hz, 32'd1);

    host_read(8'h00, 8'd3, d);  check("id_m3", d, 32'd131);
    host_read(8'h1D, 8'd0, d);  check("baud_read", d, 32'd19200);
    host_read(8'h0B, 8'd0, d);  check("mode_m0", d, 32'd3);

    host_write(8'h0C, 8'd2, 32'hFFFFFE0C);
`ifdef SHADOW_COMMIT_EN
    check("sp2_before_commit", sp_flat[64 +: 32], 32'd0);
    check("pulse_no_commit", {31'd0, update_pulse}, 32'd0);
    host_read(8'h0C, 8'd2, d);  check("sp_active_pre", d, 32'd0);
    host_read(8'h0E, 8'd2, d);  check("sp_shadow", d, 32'hFFFFFE0C);
    host_write(8'h20, 8'd0, 32'd0);
    check("pulse_commit", {31'd0, update_pulse}, 32'd1);
    check("sp2_commit", sp_flat[64 +: 32], 32'hFFFFFE0C);
    tick();
    check("pulse_one_cycle", {31'd0, update_pulse}, 32'd0);
`else
    check("pulse_direct", {31'd0, update_pulse}, 32'd1);
    check("sp2_direct", sp_flat[64 +: 32], 32'hFFFFFE0C);
    tick();
    check("pulse_one_cycle", {31'd0, update_pulse}, 32'd0);
    host_read(8'h0C, 8'd2, d);  check("sp_active", d, 32'hFFFFFE0C);
    host_read(8'h0E, 8'd2, d);  check("sp_0e_active", d, 32'hFFFFFE0C);
`endif

    host_write(8'h01, 8'd4, 32'd7);
    check("dirty_kp_m4", 32'(dirty), 32'h010);
    cfg_motor = 8'd4;
    cfg_sel   = 3'd1;
    tick();
    check("cfg_kp_m4", cfg_data, 32'd7);
    dirty_clr_valid = 1'b1;
    dirty_clr_motor = 8'd4;
    host_write(8'h02, 8'd4, 32'd9);
    dirty_clr_valid = 1'b0;
    check("dirty_set_wins", 32'(dirty), 32'h010);
    dirty_clr_valid = 1'b1;
    tick();
    dirty_clr_valid = 1'b0;
    check("dirty_cleared", 32'(dirty), 32'd0);

    stat_valid = 1'b1;
    stat_motor = 8'd1;
    stat_sel   = 2'd0;
    stat_data  = 32'h0000FFFE;
    tick();
    stat_valid = 1'b0;
    host_read(8'h04, 8'd1, d);  check("enc0_sext", d, 32'hFFFFFFFE);
    stat_valid = 1'b1;
    stat_motor = 8'd12;
    stat_data  = 32'd5;
    tick();
    stat_valid = 1'b0;
    host_read(8'h04, 8'd1, d);  check("stat_oor_ignored", d, 32'hFFFFFFFE);

    host_read(8'h01, 8'd10, d); check("rd_oor", d, 32'hDEADBEEF);
    host_read(8'h22, 8'd0, d);  check("berr_rd", d, 32'd1);
    host_read(8'h22, 8'd0, d);  check("berr_cleared", d, 32'd0);
    host_write(8'h01, 8'd15, 32'd1);
    host_read(8'h22, 8'd0, d);  check("berr_wr", d, 32'd2);
    host_read(8'h37, 8'd0, d);  check("rd_unmapped", d, 32'hDEADBEEF);
    host_read(8'h22, 8'd0, d);  check("berr_unmapped", d, 32'd4);

    host_write(8'h1D, 8'd0, 32'd9600);
    host_write(8'h01, 8'd15, 32'd1);
    address = {8'h01, 8'd4};
    read    = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("rst_mid_wait", {31'd0, waitrequest}, 32'd0);
    check("rst_mid_readdata", readdata, 32'd0);
    read = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("rst2_baud", baudrate, 32'd19200);
    check("rst2_sp2", sp_flat[64 +: 32], 32'd0);
    host_read(8'h00, 8'd3, d);  check("rst2_id_m3", d, 32'd131);
    host_read(8'h01, 8'd4, d);  check("rst2_kp_m4", d, 32'd0);
    host_read(8'h22, 8'd0, d);  check("rst2_berr", d, 32'd0);

    repeat (500) begin
      ra = ($urandom_range(0, 9) == 0) ? 8'($urandom) : ADDRS[$urandom_range(0, 19)];
      rm = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(10, 20)) : 8'($urandom_range(0, 9));
      case ($urandom_range(0, 3))
        0, 1: begin
          address   = {ra, rm};
          writedata = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 300);
          write     = 1'b1;
          rand_side();
          tick();
          write = 1'b0;
        end
        2: begin
          if (ra == 8'h20) ra = 8'h30;
          address = {ra, rm};
          read    = 1'b1;
          rand_side();
          tick();
          rand_side();
          tick();
          read = 1'b0;
        end
        default: begin
          rand_side();
          tick();
        end
      endcase
    end
    stat_valid      = 1'b0;
    dirty_clr_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/motor_bus_regfile.md
Name: motor_bus_regfile

Overview:
- Parametrised Avalon-MM register file between the HPS bridge and the motor-bus comms engine, generalising the per-motor register bank.
- Adds:
  - configurable motor count and data width
  - shadowed setpoints with atomic commit
  - per-motor dirty tracking for config push
  - a registered comms-side config read port
  - a comms-side status write port
  - sticky bus-error reporting

Parameters:
- NUMBER_OF_MOTORS, 10, motor channels; must be 1..32.
- DATA_WIDTH, 32, width of gain, limit, setpoint and status registers.
- ENC_WIDTH, 16, stored encoder width; sign-extended on read.
- ID_BASE, 128, reset id of motor i is ID_BASE+i.
- DEFAULT_BAUDRATE, 19200, reset baudrate.
- DEFAULT_CONTROL_MODE, 3, reset control_mode.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-low reset.
- address, in, 16: [15:8] register select (addr), [7:0] motor index (motor).
- write, in, 1: Avalon write.
- writedata, in, 32: write data.
- read, in, 1: Avalon read.
- readdata, out, 32: registered read data.
- waitrequest, out, 1: Avalon wait.
- stat_valid, in, 1: comms status write strobe.
- stat_motor, in, 8: status target motor.
- stat_sel, in, 2: 0 enc0, 1 enc1, 2 current, 3 error_code.
- stat_data, in, DATA_WIDTH: status value.
- cfg_motor, in, 8: comms config read motor.
- cfg_sel, in, 3: 0 id, 1 Kp, 2 Ki, 3 Kd, 4 PWMLimit, 5 IntegralLimit, 6 deadband, 7 control_mode.
- cfg_data, out, DATA_WIDTH: config value, 1-cycle latency.
- dirty, out, NUMBER_OF_MOTORS: per-motor config-changed flags.
- dirty_clr_valid, in, 1: clear strobe from comms.
- dirty_clr_motor, in, 8: motor whose dirty flag is cleared.
- sp_flat, out, NUMBER_OF_MOTORS*DATA_WIDTH: active setpoints, motor i at [i*DATA_WIDTH +: DATA_WIDTH].
- update_pulse, out, 1: one-cycle pulse when active setpoints change.
- baudrate, out, 32: bus baudrate.
- update_frequency_Hz, out, 32: comms update rate.

Behaviour:
- Reset values (reset low, asynchronous):
  - readdata=0, waitrequest=0, cfg_data=0, dirty=0, update_pulse=0, sp_flat=0
  - shadow sp=0, gains/limits/deadband=0, control_mode=DEFAULT_CONTROL_MODE, id[i]=ID_BASE+i
  - status regs=0, bus_error=0, baudrate=DEFAULT_BAUDRATE, update_frequency_Hz=1
- Register map, by addr:
  - 0x00 id, 0x01 Kp, 0x02 Ki, 0x03 Kd, 0x08 PWMLimit, 0x09 IntegralLimit, 0x0A deadband, 0x0B control_mode: RW per motor.
  - 0x04 enc0, 0x05 enc1, 0x19 current, 0x0D error_code: RO per motor.
  - 0x0C setpoint, per motor: write → shadow; read → active.
  - 0x0E: RO per motor, shadow setpoint.
  - 0x11 update_frequency_Hz, 0x1D baudrate: RW global.
  - 0x20 commit: WO.
  - 0x21: RO dirty bitmap, zero-extended.
  - 0x22: RO bus_error[2:0], cleared on read.
- Read timing:
  - Cycle 1 with read high: waitrequest=1 (combinational from read and an internal armed flag).
  - Cycle 2: readdata valid, waitrequest=0.
  - Back-to-back reads each take 2 cycles.
- Writes take effect on the cycle write is high; zero wait states. read and write are never simultaneous.
- Narrow fields: id and control_mode store writedata[7:0]. enc reads sign-extend ENC_WIDTH to 32; status stores stat_data[ENC_WIDTH-1:0] for enc.
- Errors:
  - Read with motor ≥ NUMBER_OF_MOTORS on a per-motor addr → 0xDEADBEEF, set bus_error[0].
  - Write with such a motor is ignored and sets bus_error[1].
  - Unmapped addr: read → 0xDEADBEEF, set bus_error[2]; write ignored, no error.
  - A read of 0x22 that coincides with a new error event: the new error wins.
- Dirty tracking:
  - A host write to addr 0x00–0x03 or 0x08–0x0B sets dirty[motor].
  - dirty_clr_valid clears dirty[dirty_clr_motor].
  - Set and clear on the same motor in the same cycle: set wins.
  - Out-of-range clear is ignored.
- Commit: any write to 0x20 copies all shadows to active in one cycle; update_pulse=1 the following cycle only.
- Status port: stat_valid with an in-range stat_motor updates the selected register next cycle. Out-of-range is ignored.
- Config read port: cfg_data registered every cycle from (cfg_motor, cfg_sel). Out-of-range motor → 0.

Optional Feature:
- Macro SHADOW_COMMIT_EN.
- Defined: setpoint shadow/commit as above.
- Undefined:
  - A 0x0C write updates the active setpoint directly; update_pulse fires the next cycle.
  - 0x20 writes are a no-op.
  - 0x0E reads return the active setpoint.

Test Plan:
- Reset release → read 0x00/motor 3 returns 131, waitrequest high exactly 1 cycle; read 0x1D returns 19200; read 0x0B/motor 0 returns 3.
- Write 0x0C/motor 2 = −500, read 0x0C → 0, 0x0E → −500; write 0x20 → sp_flat slice 2 = −500 and update_pulse high 1 cycle. Same sequence with SHADOW_COMMIT_EN undefined: the 0x0C read returns −500 immediately, with the pulse after the write.
- Write Kp motor 4 = 7 → dirty=0x010; cfg_motor=4, cfg_sel=1 → cfg_data=7 one cycle later; write Ki motor 4 while dirty_clr_motor=4 → dirty stays set.
- stat_valid, motor 1, sel 0, data 0x0000FFFE → read 0x04/motor 1 returns 0xFFFFFFFE; stat_motor=12 → no register change.
- Read 0x01/motor 10 → 0xDEADBEEF; read 0x22 → 1; read 0x22 again → 0; write 0x01/motor 15 → bus_error=2.
- Assert reset low mid-read (waitrequest high) → waitrequest and readdata go 0 immediately; all registers return to reset values.
